crc_job_sched: RTL and testbench
================================

Name: crc_job_sched

Overview:
- Schedules a single bit-serial CRC divider (generator x^4+x+1, 4-bit CRC) between two requesters.
- Each job is one of two kinds: an encode (compute the CRC of an 8/16/20-bit message) or a check (verify a 12/20/24-bit codeword).
- The block does round-robin arbitration, accepts message bytes MSB-first over a valid/ready bus, runs the division one bit per cycle, and returns the result through a valid/ready handshake.
- It sits between the message framers and the shared CRC datapath.

Parameters:
- NREQ, 2, number of requesters (the round-robin pointer supports 2..4).
- CRC_W, 4, CRC width.
- POLY, 4'b0011, generator low bits; the x^CRC_W term is implicit.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester job request, held until the result is accepted.
- req_op  in  NREQ  per-requester operation: 0 = encode, 1 = check.
- req_len  in  2*NREQ  per-requester length code: 0 = 8-bit msg, 1 = 16-bit, 2/3 = 20-bit.
- gnt  out  NREQ  one-hot grant, held for the whole job.
- din  in  8  message byte from the granted requester, MSB first.
- din_valid  in  1  byte valid.
- din_ready  out  1  byte accepted when din_valid && din_ready.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_crc  out  CRC_W  CRC (encode) or syndrome (check).
- res_err  out  1  check only: syndrome != 0; always 0 on encode.
- res_id  out  2  index of the requester that owns the result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: all outputs are 0, state = IDLE, remainder register = 0, round-robin pointer = 0 (requester 0 has highest priority first).
- States and transitions:
  - IDLE → LOAD when any req is high. In that cycle, grant the first requester at or after the pointer, latch its op/len, clear the remainder, set the byte counter. gnt is registered and visible from the LOAD cycle.
  - LOAD: din_ready = 1. On accept, latch the byte and set the bit count, then go to SHIFT.
  - SHIFT: one bit per cycle. r <= {r[CRC_W-2:0], b} ^ (r[CRC_W-1] ? POLY : 0).
    - When the byte's bits are done: go to LOAD if more bytes remain.
    - Else go to FLUSH for an encode, or DONE for a check.
  - FLUSH (encode only): shift CRC_W zero bits, then go to DONE.
  - DONE: res_valid = 1; res_crc = r; res_err = op & (r != 0). On res_valid && res_ready, advance the pointer to grant+1 (mod NREQ), drop gnt, go to IDLE.
- Byte and bit counts:
  - Encode lengths 8/16/20 take 1/2/3 bytes. The final byte of a 20-bit message uses din[7:4] only (4 bits).
  - Check lengths 12/20/24 take 2/3/3 bytes. The final byte uses 4, 4 and 8 bits respectively.
  - Unused low bits are ignored.
- Latency:
  - Byte accepted at cycle T with n valid bits: shifting occupies T+1..T+n.
  - Last byte: res_valid rises at T+n+1 for a check, or at T+n+CRC_W+1 for an encode.
  - IDLE→LOAD takes 1 cycle; DONE→IDLE takes 1 cycle.
- Outputs res_* stay stable while res_valid && !res_ready.
- Abort: if the granted requester's req drops in LOAD/SHIFT/FLUSH, go to IDLE next cycle. No result is produced and the pointer advances. req drops in DONE are ignored; the result must drain.
- din_valid outside LOAD is ignored. req, op and len changes by non-granted requesters mid-job have no effect.
- rst asserted mid-job returns the block to the reset state on the next edge; any partial result is discarded.

Optional Feature:
- CRC_SCHED_STATS_EN defined: adds outputs stat_jobs[15:0] and stat_errs[15:0].
  - stat_jobs counts completed result handshakes.
  - stat_errs counts handshakes with res_err = 1.
  - Both saturate at 16'hFFFF, reset to 0, and are not incremented by aborts.
- Undefined: the ports and counters are absent.

Decomposition:
- crc_pkg holds:
  - state enum (IDLE, LOAD, SHIFT, FLUSH, DONE);
  - CRC_W and POLY defaults;
  - op encodings (OP_ENC/OP_CHK);
  - a length-code function returning byte count and last-byte bit count per op.
- Sub-module crc_bit_div holds the CRC_W remainder register with clear/shift-enable and the serial bit input. The scheduler FSM and arbiter stay in crc_job_sched.

Test Plan:
- Encode, req[0], len 0, din 0xFF → 8 shift + 4 flush cycles, res_crc = 4'h4, res_err = 0, res_id = 0.
- Check, req[1], len 0, bytes 0xFF then 0x40 (codeword 0xFF4) → res_crc = 0, res_err = 0, res_id = 1; res_valid 5 cycles after the second accept.
- Check of corrupted codeword 0xFF5 (bytes 0xFF, 0x50) → res_crc = 4'h1, res_err = 1.
- Both req high from reset, two jobs each → grant order 0,1,0,1. gnt stays one-hot and constant through each job. Hold res_ready = 0 for 3 cycles → res_* stable.
- req[0] drops after the first byte of a 16-bit encode → IDLE next cycle, no res_valid, req[1] granted next.
- rst pulsed during SHIFT → all outputs 0 the next cycle. With CRC_SCHED_STATS_EN: 3 completed jobs (1 error) → stat_jobs = 3, stat_errs = 1.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC job scheduler: FSM states, op codes,
// default CRC parameters and the length-code decoder.
package crc_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, FLUSH, DONE} state_t;

   localparam int         CRC_W_DEF = 4;
   localparam logic [3:0] POLY_DEF  = 4'b0011;

   localparam logic OP_ENC = 1'b0;
   localparam logic OP_CHK = 1'b1;

   typedef struct packed {
      logic [1:0] nbytes;
      logic [3:0] last_bits;
   } len_info_t;

   // Encode lengths 8/16/20 bits, check lengths 12/20/24 bits; the final byte
   // carries only the bits that remain, left-aligned.
   function automatic len_info_t len_info(input logic op, input logic [1:0] len);
      len_info_t li;
      li = '{nbytes: 2'd1, last_bits: 4'd8};
      if (op == OP_ENC) begin
         case (len)
            2'd0:    li = '{nbytes: 2'd1, last_bits: 4'd8};
            2'd1:    li = '{nbytes: 2'd2, last_bits: 4'd8};
            default: li = '{nbytes: 2'd3, last_bits: 4'd4};
         endcase
      end else begin
         case (len)
            2'd0:    li = '{nbytes: 2'd2, last_bits: 4'd4};
            2'd1:    li = '{nbytes: 2'd3, last_bits: 4'd4};
            default: li = '{nbytes: 2'd3, last_bits: 4'd8};
         endcase
      end
      return li;
   endfunction

endpackage

// File: rtl/crc_job_sched_if.sv
// Request, message-byte and result bus between the framers and the scheduler.
// master = framer/consumer side, slave = scheduler side.
interface crc_job_sched_if
   import crc_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int CRC_W = CRC_W_DEF
);
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   req_op;
   logic [2*NREQ-1:0] req_len;
   logic [NREQ-1:0]   gnt;
   logic [7:0]        din;
   logic              din_valid;
   logic              din_ready;
   logic              res_valid;
   logic              res_ready;
   logic [CRC_W-1:0]  res_crc;
   logic              res_err;
   logic [1:0]        res_id;

   modport master (
      output req, req_op, req_len, din, din_valid, res_ready,
      input  gnt, din_ready, res_valid, res_crc, res_err, res_id
   );

   modport slave (
      input  req, req_op, req_len, din, din_valid, res_ready,
      output gnt, din_ready, res_valid, res_crc, res_err, res_id
   );
endinterface

// File: rtl/crc_bit_div.sv
// Bit-serial CRC remainder register: one message bit per enabled cycle,
// generator = x^CRC_W + POLY.
module crc_bit_div
   import crc_pkg::*;
#(
   parameter int               CRC_W = CRC_W_DEF,
   parameter logic [CRC_W-1:0] POLY  = CRC_W'(POLY_DEF)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             bit_in,
   output logic [CRC_W-1:0] rem
);
   logic [CRC_W-1:0] rem_reg;
   logic [CRC_W-1:0] rem_next;
   logic [CRC_W-1:0] shifted;

   // Shift left by one, feed bit_in at the bottom, fold the outgoing MSB back in.
   generate
      for (genvar gi = 0; gi < CRC_W; gi++) begin : g_fb
         if (gi == 0) begin : g_lsb
            assign shifted[gi] = bit_in ^ (rem_reg[CRC_W-1] & POLY[gi]);
         end else begin : g_upper
            assign shifted[gi] = rem_reg[gi-1] ^ (rem_reg[CRC_W-1] & POLY[gi]);
         end
      end
   endgenerate

   always_comb begin
      rem_next = rem_reg;
      if (clr)
         rem_next = '0;
      else if (en)
         rem_next = shifted;
   end

   always_ff @(posedge clk) begin
      if (rst)
         rem_reg <= '0;
      else
         rem_reg <= rem_next;
   end

   assign rem = rem_reg;
endmodule

// File: rtl/crc_job_sched.sv
// Round-robin scheduler sharing one bit-serial CRC divider between requesters.
// Define CRC_SCHED_STATS_EN to add the stat_jobs/stat_errs handshake counters.
module crc_job_sched
   import crc_pkg::*;
#(
   parameter int               NREQ  = 2,
   parameter int               CRC_W = CRC_W_DEF,
   parameter logic [CRC_W-1:0] POLY  = CRC_W'(POLY_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   crc_job_sched_if.slave    bus,
   output logic              busy
`ifdef CRC_SCHED_STATS_EN
  ,output logic [15:0]       stat_jobs,
   output logic [15:0]       stat_errs
`endif
);
   state_t            state_reg, state_next;
   logic [NREQ-1:0]   gnt_reg, gnt_next;
   logic [1:0]        gid_reg, gid_next;
   logic [1:0]        ptr_reg, ptr_next;
   logic              op_reg, op_next;
   logic [1:0]        bytes_left_reg, bytes_left_next;
   logic [3:0]        last_bits_reg, last_bits_next;
   logic [7:0]        shift_reg, shift_next;
   logic [3:0]        bit_cnt_reg, bit_cnt_next;

   logic              any_req;
   logic [1:0]        sel_idx;
   logic [NREQ-1:0]   sel_onehot;
   logic              sel_op;
   logic [1:0]        sel_len;
   len_info_t         sel_info;
   logic              owner_req;
   logic [1:0]        ptr_adv;
   logic              div_clr, div_en, div_bit;
   logic [CRC_W-1:0]  rem;
   logic              din_ready_int, res_valid_int, res_hs;

   // First requester at or after the pointer wins; scan far-to-near so the nearest overrides.
   always_comb begin
      int k;
      any_req = 1'b0;
      sel_idx = ptr_reg;
      for (int i = NREQ - 1; i >= 0; i--) begin
         k = int'(ptr_reg) + i;
         if (k >= NREQ)
            k = k - NREQ;
         if (bus.req[k]) begin
            any_req = 1'b1;
            sel_idx = 2'(k);
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
         assign sel_onehot[gi] = (sel_idx == 2'(gi));
      end
   endgenerate

   always_comb begin
      sel_len = 2'd0;
      for (int i = 0; i < NREQ; i++)
         if (sel_onehot[i])
            sel_len = bus.req_len[2*i +: 2];
   end

   assign sel_op    = |(bus.req_op & sel_onehot);
   assign sel_info  = len_info(sel_op, sel_len);
   assign owner_req = |(bus.req & gnt_reg);
   assign ptr_adv   = (gid_reg == 2'(NREQ - 1)) ? 2'd0 : gid_reg + 2'd1;
   assign res_hs    = res_valid_int & bus.res_ready;

   always_comb begin
      state_next      = state_reg;
      gnt_next        = gnt_reg;
      gid_next        = gid_reg;
      ptr_next        = ptr_reg;
      op_next         = op_reg;
      bytes_left_next = bytes_left_reg;
      last_bits_next  = last_bits_reg;
      shift_next      = shift_reg;
      bit_cnt_next    = bit_cnt_reg;
      div_clr         = 1'b0;
      div_en          = 1'b0;
      div_bit         = 1'b0;
      din_ready_int   = 1'b0;
      res_valid_int   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (any_req) begin
               state_next      = LOAD;
               gnt_next        = sel_onehot;
               gid_next        = sel_idx;
               op_next         = sel_op;
               bytes_left_next = sel_info.nbytes;
               last_bits_next  = sel_info.last_bits;
               div_clr         = 1'b1;
            end
         end
         LOAD: begin
            din_ready_int = 1'b1;
            if (!owner_req) begin
               state_next = IDLE;
               gnt_next   = '0;
               ptr_next   = ptr_adv;
            end else if (bus.din_valid) begin
               state_next      = SHIFT;
               shift_next      = bus.din;
               bytes_left_next = bytes_left_reg - 2'd1;
               bit_cnt_next    = (bytes_left_reg == 2'd1) ? last_bits_reg : 4'd8;
            end
         end
         SHIFT: begin
            if (!owner_req) begin
               state_next = IDLE;
               gnt_next   = '0;
               ptr_next   = ptr_adv;
            end else begin
               div_en       = 1'b1;
               div_bit      = shift_reg[7];
               shift_next   = {shift_reg[6:0], 1'b0};
               bit_cnt_next = bit_cnt_reg - 4'd1;
               if (bit_cnt_reg == 4'd1) begin
                  if (bytes_left_reg != 2'd0) begin
                     state_next = LOAD;
                  end else if (op_reg == OP_ENC) begin
                     state_next   = FLUSH;
                     bit_cnt_next = 4'(CRC_W);
                  end else begin
                     state_next = DONE;
                  end
               end
            end
         end
         FLUSH: begin
            if (!owner_req) begin
               state_next = IDLE;
               gnt_next   = '0;
               ptr_next   = ptr_adv;
            end else begin
               div_en       = 1'b1;
               bit_cnt_next = bit_cnt_reg - 4'd1;
               if (bit_cnt_reg == 4'd1)
                  state_next = DONE;
            end
         end
         DONE: begin
            // Requests dropping here are ignored: the result always drains.
            res_valid_int = 1'b1;
            if (res_hs) begin
               state_next = IDLE;
               gnt_next   = '0;
               ptr_next   = ptr_adv;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         gnt_reg        <= '0;
         gid_reg        <= 2'd0;
         ptr_reg        <= 2'd0;
         op_reg         <= 1'b0;
         bytes_left_reg <= 2'd0;
         last_bits_reg  <= 4'd0;
         shift_reg      <= 8'd0;
         bit_cnt_reg    <= 4'd0;
      end else begin
         state_reg      <= state_next;
         gnt_reg        <= gnt_next;
         gid_reg        <= gid_next;
         ptr_reg        <= ptr_next;
         op_reg         <= op_next;
         bytes_left_reg <= bytes_left_next;
         last_bits_reg  <= last_bits_next;
         shift_reg      <= shift_next;
         bit_cnt_reg    <= bit_cnt_next;
      end
   end

   crc_bit_div #(
      .CRC_W (CRC_W),
      .POLY  (POLY)
   ) u_div (
      .clk    (clk),
      .rst    (rst),
      .clr    (div_clr),
      .en     (div_en),
      .bit_in (div_bit),
      .rem    (rem)
   );

   assign bus.gnt       = gnt_reg;
   assign bus.din_ready = din_ready_int;
   assign bus.res_valid = res_valid_int;
   assign bus.res_crc   = res_valid_int ? rem : '0;
   assign bus.res_err   = res_valid_int & op_reg & (|rem);
   assign bus.res_id    = res_valid_int ? gid_reg : 2'd0;
   assign busy          = (state_reg != IDLE);

`ifdef CRC_SCHED_STATS_EN
   logic [15:0] stat_jobs_reg, stat_errs_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_jobs_reg <= 16'd0;
         stat_errs_reg <= 16'd0;
      end else if (res_hs) begin
         if (stat_jobs_reg != 16'hFFFF)
            stat_jobs_reg <= stat_jobs_reg + 16'd1;
         if (bus.res_err && stat_errs_reg != 16'hFFFF)
            stat_errs_reg <= stat_errs_reg + 16'd1;
      end
   end

   assign stat_jobs = stat_jobs_reg;
   assign stat_errs = stat_errs_reg;
`endif
endmodule

// File: tb/tb_crc_job_sched.sv
// Randomized self-checking bench for crc_job_sched; expected CRCs come from
// whole-message polynomial division, grants from a round-robin pointer model.
module tb_crc_job_sched;

   typedef struct {
      logic        op;
      logic [1:0]  len;
      logic [31:0] msg;
   } job_t;

   logic clk = 1'b0;
   logic rst;
   logic busy;
`ifdef CRC_SCHED_STATS_EN
   logic [15:0] stat_jobs, stat_errs;
`endif

   always #5 clk = ~clk;

   crc_job_sched_if #(.NREQ(2), .CRC_W(4)) bus ();

   crc_job_sched #(
      .NREQ  (2),
      .CRC_W (4),
      .POLY  (4'b0011)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .busy      (busy)
`ifdef CRC_SCHED_STATS_EN
     ,.stat_jobs (stat_jobs),
      .stat_errs (stat_errs)
`endif
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   job_t jq[2][$];
   int   ptr_m    = 0;
   int   exp_jobs = 0;
   int   exp_errs = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int msg_bits(input logic op, input logic [1:0] len);
      if (op == 1'b0) return (len == 2'd0) ? 8  : (len == 2'd1) ? 16 : 20;
      else            return (len == 2'd0) ? 12 : (len == 2'd1) ? 20 : 24;
   endfunction

   // Remainder of val(x) modulo x^4 + x + 1, val having nbits significant bits.
   function automatic logic [3:0] crc_ref(input logic [31:0] val, input int nbits);
      logic [31:0] v;
      v = val;
      for (int i = nbits - 1; i >= 4; i--)
         if (v[i]) v = v ^ (32'h13 << (i - 4));
      return v[3:0];
   endfunction

   function automatic job_t rand_job();
      job_t j;
      int   L;
      logic [31:0] m;
      j.op  = 1'($urandom);
      j.len = 2'($urandom);
      L     = msg_bits(j.op, j.len);
      if (j.op && $urandom_range(0, 1) == 1) begin
         m     = $urandom & ((32'd1 << (L - 4)) - 1);
         j.msg = (m << 4) | 32'(crc_ref(m << 4, L));
      end else begin
         j.msg = $urandom & ((32'd1 << L) - 1);
      end
      return j;
   endfunction

   task automatic present();
      for (int i = 0; i < 2; i++) begin
         bus.req[i] = (jq[i].size() > 0);
         if (jq[i].size() > 0) begin
            bus.req_op[i]         = jq[i][0].op;
            bus.req_len[2*i +: 2] = jq[i][0].len;
         end
      end
   endtask

   function automatic int pick();
      int idx;
      for (int k = 0; k < 2; k++) begin
         idx = (ptr_m + k) % 2;
         if (jq[idx].size() > 0) return idx;
      end
      return 0;
   endfunction

   task automatic wait_gnt();
      int w = 0;
      while (bus.gnt == 2'b00 && w < 10) begin
         @(negedge clk);
         w++;
      end
   endtask

   // Present one byte once LOAD is reached; junk on din_valid and on the other
   // requester's op/len while waiting must be ignored.
   task automatic send_byte(input int e, input logic [7:0] b);
      int w = 0;
      while (!bus.din_ready && w < 20) begin
         bus.din_valid                  = 1'($urandom);
         bus.din                        = 8'($urandom);
         bus.req_op[1-e]                = 1'($urandom);
         bus.req_len[2*(1-e) +: 2]      = 2'($urandom);
         @(negedge clk);
         w++;
      end
      check_val("din_ready", 32'(bus.din_ready), 32'd1);
      repeat ($urandom_range(0, 2)) begin
         bus.din_valid = 1'b0;
         bus.din       = 8'($urandom);
         @(negedge clk);
      end
      bus.din_valid = 1'b1;
      bus.din       = b;
      @(negedge clk);
      bus.din_valid = 1'b0;
      bus.din       = 8'($urandom);
   endtask

   function automatic logic [7:0] job_byte(input job_t j, input int b);
      int L, nb, pad;
      logic [31:0] padded;
      logic [7:0]  v;
      L      = msg_bits(j.op, j.len);
      nb     = (L + 7) / 8;
      pad    = 8 * nb - L;
      padded = j.msg << pad;
      v      = 8'(padded >> (8 * (nb - 1 - b)));
      if (b == nb - 1)
         v = v | (8'($urandom) & 8'((1 << pad) - 1));
      return v;
   endfunction

   task automatic serve(output logic [3:0] crc_o, output logic err_o);
      int   e, L, nb, lastn, lat, k, hold;
      job_t j;
      logic [3:0] exp_crc;
      logic       exp_err;
      e     = pick();
      j     = jq[e][0];
      L     = msg_bits(j.op, j.len);
      nb    = (L + 7) / 8;
      lastn = L - 8 * (nb - 1);
      wait_gnt();
      check_val("gnt", 32'(bus.gnt), 32'(1 << e));
      for (int b = 0; b < nb; b++) begin
         send_byte(e, job_byte(j, b));
         check_val("gnt_hold", 32'(bus.gnt), 32'(1 << e));
      end
      lat = lastn + 1 + ((j.op == 1'b0) ? 4 : 0);
      k = 1;
      while (!bus.res_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      check_val("latency", 32'(k), 32'(lat));
      if (j.op == 1'b0) begin
         exp_crc = crc_ref(j.msg << 4, L + 4);
         exp_err = 1'b0;
      end else begin
         exp_crc = crc_ref(j.msg, L);
         exp_err = (exp_crc != 4'd0);
      end
      hold = $urandom_range(0, 3);
      bus.res_ready = 1'b0;
      for (int h = 0; h <= hold; h++) begin
         check_val("res_valid", 32'(bus.res_valid), 32'd1);
         check_val("res_crc",   32'(bus.res_crc),   32'(exp_crc));
         check_val("res_err",   32'(bus.res_err),   32'(exp_err));
         check_val("res_id",    32'(bus.res_id),    32'(e));
         check_val("gnt_done",  32'(bus.gnt),       32'(1 << e));
         if (h < hold) @(negedge clk);
      end
      crc_o = bus.res_crc;
      err_o = bus.res_err;
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      check_val("res_valid_drop", 32'(bus.res_valid), 32'd0);
      check_val("gnt_drop",       32'(bus.gnt),       32'd0);
      $display("job req=%0d op=%0d len=%0d msg=%h crc=%h err=%0b hold=%0d",
               e, j.op, j.len, j.msg, crc_o, err_o, hold);
      void'(jq[e].pop_front());
      ptr_m = (e + 1) % 2;
      exp_jobs++;
      if (exp_err) exp_errs++;
      present();
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_gnt"},       32'(bus.gnt),       32'd0);
      check_val({tag, "_busy"},      32'(busy),          32'd0);
      check_val({tag, "_din_ready"}, 32'(bus.din_ready), 32'd0);
      check_val({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
      check_val({tag, "_res_crc"},   32'(bus.res_crc),   32'd0);
      check_val({tag, "_res_err"},   32'(bus.res_err),   32'd0);
      check_val({tag, "_res_id"},    32'(bus.res_id),    32'd0);
   endtask

   function automatic job_t mk(input logic op, input logic [1:0] len, input logic [31:0] msg);
      job_t j;
      j.op = op; j.len = len; j.msg = msg;
      return j;
   endfunction

   initial begin
      logic [3:0] c;
      logic       er;
      job_t       j;
      rst           = 1'b1;
      bus.req       = '0;
      bus.req_op    = '0;
      bus.req_len   = '0;
      bus.din       = '0;
      bus.din_valid = 1'b0;
      bus.res_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;

      // Directed vectors with known results.
      jq[0].push_back(mk(1'b0, 2'd0, 32'hFF));
      present();
      serve(c, er);
      check_val("enc_ff_crc", 32'(c), 32'h4);
      check_val("enc_ff_err", 32'(er), 32'd0);

      jq[1].push_back(mk(1'b1, 2'd0, 32'hFF4));
      present();
      serve(c, er);
      check_val("chk_ff4_crc", 32'(c), 32'h0);
      check_val("chk_ff4_err", 32'(er), 32'd0);

      jq[1].push_back(mk(1'b1, 2'd0, 32'hFF5));
      present();
      serve(c, er);
      check_val("chk_ff5_crc", 32'(c), 32'h1);
      check_val("chk_ff5_err", 32'(er), 32'd1);

      // Both requesters with two jobs each: grants must alternate 0,1,0,1.
      for (int n = 0; n < 2; n++) begin
         jq[0].push_back(rand_job());
         jq[1].push_back(rand_job());
      end
      present();
      while (jq[0].size() + jq[1].size() > 0) serve(c, er);

      // Abort: requester 0 drops req after the first byte of a 16-bit encode.
      j = mk(1'b0, 2'd1, $urandom & 32'hFFFF);
      jq[0].push_back(j);
      jq[1].push_back(rand_job());
      present();
      wait_gnt();
      check_val("abort_gnt", 32'(bus.gnt), 32'd1);
      send_byte(0, job_byte(j, 0));
      bus.req[0] = 1'b0;
      @(negedge clk);
      check_val("abort_busy",      32'(busy),          32'd0);
      check_val("abort_gnt_drop",  32'(bus.gnt),       32'd0);
      check_val("abort_res_valid", 32'(bus.res_valid), 32'd0);
      $display("abort req=0 msg=%h", j.msg);
      void'(jq[0].pop_front());
      ptr_m = 1;
      present();
      serve(c, er);

      // Reset during SHIFT discards the job and every counter.
      j = mk(1'b0, 2'd2, $urandom & 32'hFFFFF);
      jq[0].push_back(j);
      present();
      wait_gnt();
      send_byte(0, job_byte(j, 0));
      rst = 1'b1;
      jq[0].delete();
      present();
      @(negedge clk);
      check_idle_outputs("midrst");
      rst      = 1'b0;
      ptr_m    = 0;
      exp_jobs = 0;
      exp_errs = 0;
      $display("reset mid-job msg=%h", j.msg);

      // Random batches.
      for (int batch = 0; batch < 6; batch++) begin
         repeat ($urandom_range(1, 3)) jq[0].push_back(rand_job());
         repeat ($urandom_range(0, 3)) jq[1].push_back(rand_job());
         present();
         while (jq[0].size() + jq[1].size() > 0) serve(c, er);
      end

`ifdef CRC_SCHED_STATS_EN
      check_val("stat_jobs", 32'(stat_jobs), 32'(exp_jobs));
      check_val("stat_errs", 32'(stat_errs), 32'(exp_errs));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
